// File: rtl/regfile_wb_ctrl.sv
// Write-back controller in front of the register file's single write port.
// After reset it walks x1..x31 writing zero. It then merges the unstallable
// ALU write-back with a small FIFO of load results. Pending load destinations
// are exported as pend_mask for the hazard unit.
//
// Load handshake: a load transfers on the rising edge where ld_valid and
// ld_ready are both high. ld_ready depends only on registered state, so it
// never depends combinationally on ld_valid. A load to x0 is accepted and
// discarded.
module regfile_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        write,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    output logic        busy,
    output logic        drain_req,
    output logic [31:0] pend_mask,
    output logic        dbgState
);

    localparam int PW = 2;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_C  = 3'(DEPTH);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} stateT;

    stateT            stateQ, stateD;
    logic [5:0]       cntQ, cntD;
    logic [4:0]       entRd   [DEPTH];
    logic [31:0]      entData [DEPTH];
    logic [DEPTH-1:0] entLive, liveNext;
    logic [PW-1:0]    rdPtr, wrPtr;
    logic [2:0]       countQ;
    logic             aluWr, pushEn, popEn, headLive;
    logic [31:0]      headData;
    logic [4:0]       rdNext;
    logic [31:0]      maskNext;
    logic             nxtWrite;
    logic [4:0]       nxtAddr;
    logic [31:0]      nxtData;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign busy      = (stateQ == CLEAR);
    assign drain_req = (countQ == DEPTH_C);
    assign dbgState  = (stateQ == RUN);

    // Handshake and arbitration: the ALU always wins; a pop frees no slot this cycle
    always_comb begin
        ld_ready = (stateQ == RUN) && (countQ < DEPTH_C);
        aluWr    = (stateQ == RUN) && alu_valid && (alu_rd != 5'd0);
        pushEn   = ld_ready && ld_valid && (ld_rd != 5'd0);
        popEn    = (stateQ == RUN) && !aluWr && (countQ != 3'd0);
    end

    // Head-of-FIFO selection without indexing by a pointer wider than the array
    always_comb begin
        headData = '0;
        headLive = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdPtr == PW'(i)) begin
                headData = entData[i];
                headLive = entLive[i];
            end
        end
    end

    // Next live bits (kill, then pop, then push) and the scoreboard they imply
    always_comb begin
        liveNext = entLive;
        maskNext = '0;
        rdNext   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdNext = entRd[i];
            if (aluWr && (entRd[i] == alu_rd)) liveNext[i] = 1'b0;
            if (popEn && (rdPtr == PW'(i)))    liveNext[i] = 1'b0;
            if (pushEn && (wrPtr == PW'(i))) begin
                liveNext[i] = 1'b1;
                rdNext      = ld_rd;
            end
            if (liveNext[i]) maskNext[rdNext] = 1'b1;
        end
        maskNext[0] = 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateQ <= CLEAR;
        else     stateQ <= stateD;
    end

    // FSM next state: leave CLEAR one edge after x31 has been issued
    always_comb begin
        stateD = stateQ;
        if ((stateQ == CLEAR) && (cntQ == 6'd32)) stateD = RUN;
    end

    // FSM outputs: next values for the write port and clear counter
    always_comb begin
        nxtWrite = 1'b0;
        nxtAddr  = wrAddr;
        nxtData  = wrData;
        cntD     = cntQ;
        case (stateQ)
            CLEAR: begin
                if (cntQ != 6'd32) begin
                    nxtWrite = 1'b1;
                    nxtAddr  = cntQ[4:0];
                    nxtData  = '0;
                    cntD     = cntQ + 6'd1;
                end
            end
            RUN: begin
                if (aluWr) begin
                    nxtWrite = 1'b1;
                    nxtAddr  = alu_rd;
                    nxtData  = alu_data;
                end else if (popEn && headLive) begin
                    nxtWrite = 1'b1;
                    nxtAddr  = 5'(headRdSel());
                    nxtData  = headData;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [4:0] headRdSel();
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) if (rdPtr == PW'(i)) r = entRd[i];
        return r;
    endfunction

    // Registered write port, clear counter and scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntQ      <= 6'd1;
            write     <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            pend_mask <= '0;
        end else begin
            cntQ      <= cntD;
            write     <= nxtWrite;
            wrAddr    <= nxtAddr;
            wrData    <= nxtData;
            pend_mask <= maskNext;
        end
    end

    // Load FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            countQ  <= '0;
            entLive <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entRd[i]   <= '0;
                entData[i] <= '0;
            end
        end else begin
            entLive <= liveNext;
            for (int i = 0; i < DEPTH; i++) begin
                if (pushEn && (wrPtr == PW'(i))) begin
                    entRd[i]   <= ld_rd;
                    entData[i] <= ld_data;
                end
            end
            if (pushEn) wrPtr <= ptrInc(wrPtr);
            if (popEn)  rdPtr <= ptrInc(rdPtr);
            if (pushEn && !popEn)      countQ <= countQ + 3'd1;
            else if (!pushEn && popEn) countQ <= countQ - 3'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: clear sequence, ALU path, load FIFO,
// WAW kill and mid-run reset.
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        busy;
    logic        drain_req;
    logic [31:0] pend_mask;
    logic        dbgState;

    int checks   = 0;
    int failures = 0;

    regfile_wb_ctrl #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy), .drain_req(drain_req), .pend_mask(pend_mask),
        .dbgState(dbgState)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", write); end
        checks++; if (wrAddr !== 5'd0) begin failures++; $display("FAIL rst_wrAddr got=%0d exp=0", wrAddr); end
        checks++; if (wrData !== 32'd0) begin failures++; $display("FAIL rst_wrData got=%h exp=0", wrData); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got=%0b exp=0", ld_ready); end
        checks++; if (drain_req !== 1'b0) begin failures++; $display("FAIL rst_drain_req got=%0b exp=0", drain_req); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL rst_pend_mask got=%h exp=0", pend_mask); end
        // Inputs offered during clear must be ignored
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hFFFF_FFFF;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h6666;
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            checks++; if (write !== 1'b1) begin failures++; $display("FAIL clr_write E%0d got=%0b exp=1", k, write); end
            checks++; if (wrAddr !== 5'(k)) begin failures++; $display("FAIL clr_wrAddr E%0d got=%0d exp=%0d", k, wrAddr, k); end
            checks++; if (wrData !== 32'd0) begin failures++; $display("FAIL clr_wrData E%0d got=%h exp=0", k, wrData); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy E%0d got=%0b exp=1", k, busy); end
            checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL clr_ld_ready E%0d got=%0b exp=0", k, ld_ready); end
        end
        tick();
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL e32_write got=%0b exp=0", write); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL e32_busy got=%0b exp=0", busy); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL e32_ld_ready got=%0b exp=1", ld_ready); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL e32_pend_mask got=%h exp=0", pend_mask); end
        idle_inputs();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        checks++; if (write !== 1'b1) begin failures++; $display("FAIL alu_write got=%0b exp=1", write); end
        checks++; if (wrAddr !== 5'd5) begin failures++; $display("FAIL alu_wrAddr got=%0d exp=5", wrAddr); end
        checks++; if (wrData !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wrData got=%h exp=deadbeef", wrData); end
        alu_rd = 5'd0; alu_data = 32'h1111;
        tick();
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL alu_x0_write got=%0b exp=0", write); end
        checks++; if (wrAddr !== 5'd5) begin failures++; $display("FAIL alu_x0_hold_addr got=%0d exp=5", wrAddr); end
        checks++; if (wrData !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_x0_hold_data got=%h exp=deadbeef", wrData); end
        idle_inputs();
        tick();
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL alu_idle_write got=%0b exp=0", write); end
    endtask

    task automatic test_load_behind_alu();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h1234;
        tick();
        ld_valid = 1'b0;
        checks++; if (wrAddr !== 5'd3 || write !== 1'b1) begin failures++; $display("FAIL lba_alu1 got=%0b/%0d exp=1/3", write, wrAddr); end
        checks++; if (pend_mask !== 32'h80) begin failures++; $display("FAIL lba_pend1 got=%h exp=00000080", pend_mask); end
        for (int c = 2; c <= 3; c++) begin
            alu_data = 32'(c);
            tick();
            checks++; if (wrAddr !== 5'd3 || wrData !== 32'(c)) begin failures++; $display("FAIL lba_alu%0d got=%0d/%h exp=3/%h", c, wrAddr, wrData, c); end
            checks++; if (pend_mask !== 32'h80) begin failures++; $display("FAIL lba_pend%0d got=%h exp=00000080", c, pend_mask); end
        end
        alu_valid = 1'b0;
        tick();
        checks++; if (write !== 1'b1 || wrAddr !== 5'd7) begin failures++; $display("FAIL lba_ld_write got=%0b/%0d exp=1/7", write, wrAddr); end
        checks++; if (wrData !== 32'h1234) begin failures++; $display("FAIL lba_ld_data got=%h exp=00001234", wrData); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL lba_pend_clear got=%h exp=0", pend_mask); end
        tick();
        checks++; if (write !== 1'b0) begin failures++; $display("FAIL lba_after got=%0b exp=0", write); end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        ld_valid  = 1'b1; ld_rd  = 5'd8;  ld_data  = 32'h88;
        tick();
        checks++; if (pend_mask !== 32'h100) begin failures++; $display("FAIL full_pend1 got=%h exp=00000100", pend_mask); end
        checks++; if (ld_ready !== 1'b1 || drain_req !== 1'b0) begin failures++; $display("FAIL full_one got=%0b/%0b exp=1/0", ld_ready, drain_req); end
        ld_rd = 5'd9; ld_data = 32'h99;
        tick();
        checks++; if (pend_mask !== 32'h300) begin failures++; $display("FAIL full_pend2 got=%h exp=00000300", pend_mask); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_ld_ready got=%0b exp=0", ld_ready); end
        checks++; if (drain_req !== 1'b1) begin failures++; $display("FAIL full_drain_req got=%0b exp=1", drain_req); end
        ld_rd = 5'd11; ld_data = 32'hBB;
        tick();
        checks++; if (ld_ready !== 1'b0 || pend_mask !== 32'h300) begin failures++; $display("FAIL full_held got=%0b/%h exp=0/00000300", ld_ready, pend_mask); end
        checks++; if (write !== 1'b1 || wrAddr !== 5'd10) begin failures++; $display("FAIL full_alu got=%0b/%0d exp=1/10", write, wrAddr); end
        alu_valid = 1'b0;
        tick();
        checks++; if (write !== 1'b1 || wrAddr !== 5'd8 || wrData !== 32'h88) begin failures++; $display("FAIL full_pop8 got=%0b/%0d/%h exp=1/8/88", write, wrAddr, wrData); end
        checks++; if (pend_mask !== 32'h200 || ld_ready !== 1'b1) begin failures++; $display("FAIL full_after8 got=%h/%0b exp=00000200/1", pend_mask, ld_ready); end
        tick();
        ld_valid = 1'b0;
        checks++; if (write !== 1'b1 || wrAddr !== 5'd9 || wrData !== 32'h99) begin failures++; $display("FAIL full_pop9 got=%0b/%0d/%h exp=1/9/99", write, wrAddr, wrData); end
        checks++; if (pend_mask !== 32'h800) begin failures++; $display("FAIL full_pushpop got=%h exp=00000800", pend_mask); end
        tick();
        checks++; if (write !== 1'b1 || wrAddr !== 5'd11 || wrData !== 32'hBB) begin failures++; $display("FAIL full_pop11 got=%0b/%0d/%h exp=1/11/bb", write, wrAddr, wrData); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL full_pend_end got=%h exp=0", pend_mask); end
        tick();
        checks++; if (write !== 1'b0 || drain_req !== 1'b0) begin failures++; $display("FAIL full_idle got=%0b/%0b exp=0/0", write, drain_req); end
        idle_inputs();
    endtask

    task automatic test_waw_kill();
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'hAAAA;
        tick();
        ld_valid = 1'b0;
        checks++; if (pend_mask !== 32'h10 || write !== 1'b0) begin failures++; $display("FAIL waw_queued got=%h/%0b exp=00000010/0", pend_mask, write); end
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h5555;
        tick();
        alu_valid = 1'b0;
        checks++; if (write !== 1'b1 || wrAddr !== 5'd4 || wrData !== 32'h5555) begin failures++; $display("FAIL waw_alu got=%0b/%0d/%h exp=1/4/5555", write, wrAddr, wrData); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL waw_kill_mask got=%h exp=0", pend_mask); end
        tick();
        checks++; if (write !== 1'b0 || wrData !== 32'h5555) begin failures++; $display("FAIL waw_dead_pop got=%0b/%h exp=0/5555", write, wrData); end
        tick();
        checks++; if (write !== 1'b0 || ld_ready !== 1'b1 || drain_req !== 1'b0) begin failures++; $display("FAIL waw_empty got=%0b/%0b/%0b exp=0/1/0", write, ld_ready, drain_req); end
        // A load accepted on the same edge as the ALU write is the younger one
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h5555;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hCCCC;
        tick();
        idle_inputs();
        checks++; if (pend_mask !== 32'h10) begin failures++; $display("FAIL waw_same_edge_mask got=%h exp=00000010", pend_mask); end
        tick();
        checks++; if (write !== 1'b1 || wrAddr !== 5'd4 || wrData !== 32'hCCCC) begin failures++; $display("FAIL waw_same_edge_pop got=%0b/%0d/%h exp=1/4/cccc", write, wrAddr, wrData); end
    endtask

    task automatic test_alu_x0_pop();
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h1212;
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hF0F0;
        tick();
        idle_inputs();
        checks++; if (write !== 1'b1 || wrAddr !== 5'd12 || wrData !== 32'h1212) begin failures++; $display("FAIL x0_pop got=%0b/%0d/%h exp=1/12/1212", write, wrAddr, wrData); end
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL x0_pop_mask got=%h exp=0", pend_mask); end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data = 32'hD;
        tick();
        ld_rd = 5'd14; ld_data = 32'hE;
        tick();
        checks++; if (pend_mask !== 32'h6000 || drain_req !== 1'b1) begin failures++; $display("FAIL mid_pre got=%h/%0b exp=00006000/1", pend_mask, drain_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pend_mask !== 32'd0) begin failures++; $display("FAIL mid_pend got=%h exp=0", pend_mask); end
        checks++; if (write !== 1'b0 || wrAddr !== 5'd0) begin failures++; $display("FAIL mid_write got=%0b/%0d exp=0/0", write, wrAddr); end
        checks++; if (busy !== 1'b1 || ld_ready !== 1'b0 || drain_req !== 1'b0) begin failures++; $display("FAIL mid_ctl got=%0b/%0b/%0b exp=1/0/0", busy, ld_ready, drain_req); end
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            checks++; if (write !== 1'b1 || wrAddr !== 5'(k) || wrData !== 32'd0) begin failures++; $display("FAIL mid_clr E%0d got=%0b/%0d/%h exp=1/%0d/0", k, write, wrAddr, wrData, k); end
        end
        tick();
        checks++; if (busy !== 1'b0 || write !== 1'b0) begin failures++; $display("FAIL mid_e32 got=%0b/%0b exp=0/0", busy, write); end
        tick();
        checks++; if (write !== 1'b0 || pend_mask !== 32'd0) begin failures++; $display("FAIL mid_flushed got=%0b/%h exp=0/0", write, pend_mask); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_behind_alu();
        test_fifo_full();
        test_waw_kill();
        test_alu_x0_pop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller directly upstream of the register file's single write port (`write`, `wrAddr`, `wrData`). After reset it zeroes x1..x31, because EBR contents are undefined at power-up. It then merges two write-back sources into the one port: the in-order ALU pipeline, which cannot be stalled mid-cycle, and the variable-latency load unit, which uses a valid/ready handshake. Pending load destinations are exported as a scoreboard mask so the hazard unit can stall dependent reads.

## Interface

- `DEPTH`, 2: load write-back FIFO entries (2..4).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU write-back present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  load result accepted on the edge where `ld_valid & ld_ready`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `write`  out  1  register-file write enable (registered).
- `wrAddr`  out  5  register-file write address (registered).
- `wrData`  out  32  register-file write data (registered).
- `busy`  out  1  clear sequence in progress; the pipeline holds fetch.
- `drain_req`  out  1  FIFO full; the hazard unit forces `alu_valid=0` next cycle.
- `pend_mask`  out  32  bit r set while a live FIFO entry targets xr; bit 0 always 0.

## Operation

- **States:** CLEAR and RUN. `rst` forces CLEAR with clear counter = 1.
- **CLEAR**
  - Every edge drives `write=1`, `wrAddr=cnt`, `wrData=0`, then increments `cnt`.
  - After `cnt=31` is issued, the state moves to RUN.
  - `alu_valid` and `ld_valid` are ignored, and `ld_ready=0`.
- **RUN priority, evaluated each edge:**
  - `alu_valid & alu_rd!=0` → emit the ALU write.
  - Else, if the FIFO has a live head → pop it and emit it.
  - Else, if the head is dead → pop it silently, with `write=0`.
  - Else `write=0`. `wrAddr` and `wrData` hold their last values.
- **ALU to x0:** `alu_rd==0` is dropped and does not block a FIFO pop that cycle.
- **Load accept:**
  - `ld_ready = (state==RUN) & (count<DEPTH)`, computed from registered count only. A pop does not free a slot in the same cycle.
  - An accepted load with `ld_rd==0` is discarded and consumes no slot.
- **Simultaneous push and pop:** legal, and count is unchanged.
- **WAW kill:** an ALU write to rd kills every live FIFO entry with the same rd, because the ALU result is architecturally younger.
  - A killed entry clears its live bit and stays in the FIFO until popped as a dead head.
  - A load accepted on the same edge as an ALU write to the same rd is treated as younger and stays live.
- **Scoreboard:** `pend_mask` is the OR of one-hot(rd) over live entries, registered, updated on the same edge as push, pop and kill.
- **Other outputs:** `drain_req = (count==DEPTH)`. `busy = (state==CLEAR)`.
- **Mid-operation reset:** `rst` mid-operation flushes the FIFO, clears `pend_mask`, and restarts CLEAR from x1.

## Timing

- **Reset values:** `write=0`, `wrAddr=0`, `wrData=0`, `busy=1`, `ld_ready=0`, `drain_req=0`, `pend_mask=0`, FIFO empty.
- **Clear sequence:** with E1 as the first rising edge after `rst` falls, edges E1..E31 present `wrAddr=1..31` with `write=1`, `wrData=0`.
  - `busy` stays 1 through E31 and is 0 after E32.
  - `write` after E32 follows RUN rules.
- **ALU latency:** 1 cycle, input edge to `write` high.
- **Load latency:** minimum 2 cycles, accept edge to `write`. The entry becomes poppable on the edge after the push.
- **Throughput:** at most one register-file write per cycle.
- **Load drain:** loads drain only in cycles with no valid non-x0 ALU write.

## Test plan

1. **Reset clear:** release `rst`, hold inputs idle → 31 writes at x1..x31 with data 0 on E1..E31; `busy` falls after E32; `ld_ready` rises at the same time.
2. **ALU only:** `alu_valid=1`, `alu_rd=5`, `alu_data=32'hDEADBEEF` → next cycle `write=1`, `wrAddr=5`, `wrData=DEADBEEF`. A write with `alu_rd=0` → `write=0`.
3. **Load behind ALU:**
   - Stimulus: load x7 = `32'h1234` accepted while the ALU writes x3 for 3 consecutive cycles.
   - Required response: `pend_mask[7]=1` throughout; the x7 write appears the cycle after the ALU stream ends; `pend_mask[7]` then clears.
4. **FIFO full:**
   - Stimulus: with `DEPTH=2`, accept loads to x8 and x9 under continuous ALU writes.
   - Required response: `ld_ready=0` and `drain_req=1`. A third `ld_valid` is held off until the hazard unit drops `alu_valid`; then x8 and x9 write in order.
5. **WAW kill:**
   - Stimulus: queue load x4 = `32'hAAAA`, then ALU writes x4 = `32'h5555`.
   - Required response: `pend_mask[4]` clears on the ALU edge; the dead entry is popped with `write=0`; x4 is never written with AAAA.
6. **Mid-run reset:** assert `rst` with 2 live FIFO entries → `pend_mask=0` immediately, `write=0`, and the clear sequence restarts from x1 after release.
